osc_wave_gen: RTL and testbench

Time-multiplexed multi-waveform oscillator engine for all `VOICES*V_OSC` oscillator slots. It is the parametrised successor to the single-sine oscillator stage. It keeps per-slot phase accumulators internally, applies per-oscillator coarse offset, fine detune and hard sync, and emits one signed sample per slot per `sCLK_XVXOSC` cycle, tagged with voice and oscillator index. Waveform per oscillator is selectable: sine, saw, square or triangle. Sits between the pitch generator and the envelope/mixer stage.

---
 rtl/osc_wave_gen_pkg.sv | 9 +
 rtl/osc_wave_gen_sine_rom.sv | 42 ++++
 rtl/osc_wave_gen.sv | 138 +++++++++++++
 tb/tb_osc_wave_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/osc_wave_gen_pkg.sv
// osc_pkg: shared wave, config-field and state encodings for the oscillator engine.
package osc_pkg;
    typedef enum logic [1:0] {WAVE_SINE, WAVE_SAW, WAVE_SQUARE, WAVE_TRI} wave_t;
    localparam logic [1:0] CFG_COARSE = 2'd0;
    localparam logic [1:0] CFG_DETUNE = 2'd1;
    localparam logic [1:0] CFG_WAVE   = 2'd2;
    localparam logic [0:0] OSC_CLEAR  = 1'b0;
    localparam logic [0:0] OSC_RUN    = 1'b1;
endpackage

// File: rtl/osc_wave_gen_sine_rom.sv
// osc_sine_rom: quarter-wave sine table with registered signed output.
// Entries sample the half-LSB-offset points so the mirrored quadrants index with a bitwise invert.
module osc_sine_rom #(
    parameter int LUT_AW = 11,
    parameter int OUT_W  = 17
) (
    input  logic                    sCLK_XVXOSC,
    input  logic [LUT_AW-1:0]       addr,
    output logic signed [OUT_W-1:0] q
);
    localparam int Q = 1 << (LUT_AW - 2);
    localparam longint HALF_PI = 64'sd1686629713;
    localparam longint AMP = (longint'(1) <<< (OUT_W - 1)) - 1;

    // Taylor series in Q30 fixed point, evaluated at elaboration only
    function automatic logic [OUT_W-2:0] mag(input int i);
        longint x, x2, t, s;
        x = (longint'(2 * i + 1) * HALF_PI) / longint'(2 * Q);
        x2 = (x * x) >>> 30;
        t = x;
        s = x;
        for (int k = 1; k <= 6; k++) begin
            t = -((t * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            s = s + t;
        end
        return (OUT_W-1)'((s * AMP + (longint'(1) <<< 29)) >>> 30);
    endfunction

    logic [OUT_W-2:0] tbl [Q];
    logic [LUT_AW-3:0] idx;
    logic [OUT_W-2:0] m;

    for (genvar i = 0; i < Q; i++) begin : g_tbl
        assign tbl[i] = mag(i);
    end

    assign idx = addr[LUT_AW-2] ? ~addr[LUT_AW-3:0] : addr[LUT_AW-3:0];
    assign m = tbl[idx];

    always_ff @(posedge sCLK_XVXOSC)
        q <= addr[LUT_AW-1] ? -{1'b0, m} : {1'b0, m};
endmodule

// File: rtl/osc_wave_gen.sv
// osc_wave_gen: time-multiplexed multi-waveform oscillator engine, one slot per clock.
// Pipeline: phase RAM read, accumulate and write back, table address, wave shaping.
module osc_wave_gen
    import osc_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int V_WIDTH = $clog2(VOICES),
    parameter int O_WIDTH = $clog2(V_OSC),
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 11,
    parameter int OUT_W   = 17
) (
    input  logic                    sCLK_XVXOSC,
    input  logic                    reset_data_N,
    input  logic                    slot_start,
    input  logic [PHASE_W-1:0]      pitch_val,
    input  logic [VOICES-1:0]       sync_zero,
    input  logic                    cfg_we,
    input  logic [O_WIDTH-1:0]      cfg_osc,
    input  logic [1:0]              cfg_field,
    input  logic [7:0]              cfg_data,
    output logic signed [OUT_W-1:0] wave_out,
    output logic                    wave_valid,
    output logic [V_WIDTH-1:0]      wave_vx,
    output logic [O_WIDTH-1:0]      wave_ox
);
    localparam int SLOTS = VOICES * V_OSC;
    localparam int S_W = V_WIDTH + O_WIDTH;
    localparam logic [OUT_W-1:0] AMP = OUT_W'((1 << (OUT_W - 1)) - 1);

    logic [0:0] state;
    logic clear, fwd, we, s1_valid, s2_valid, s3_valid;
    logic [S_W-1:0] slot_q, slot, wr_addr, s1_slot, s2_slot, s3_slot;
    logic [PHASE_W-1:0] ram [SLOTS];
    logic [PHASE_W-1:0] ram_q, fwd_data, phase, next, wr_data, s1_pitch, s2_phase;
    logic [7:0] coarse [V_OSC];
    logic [7:0] detune [V_OSC];
    wave_t wave [V_OSC];
    wave_t s3_wave;
    logic [V_WIDTH-1:0] vx1;
    logic [O_WIDTH-1:0] ox1, ox2;
    logic [LUT_AW-1:0] addr, s3_addr;
    logic [LUT_AW-2:0] fold;
    logic [OUT_W-1:0] rom_q, saw, sq, tri_v, shaped;

    assign clear = state == OSC_CLEAR;
    assign slot = slot_start ? '0 : slot_q;

    always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N)
        if (!reset_data_N) begin
            state <= OSC_CLEAR;
            slot_q <= '0;
        end else begin
            slot_q <= slot + 1'b1;
            if (clear && slot == S_W'(SLOTS - 1))
                state <= OSC_RUN;
        end

    always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N)
        if (!reset_data_N) begin
            for (int i = 0; i < V_OSC; i++) begin
                coarse[i] <= '0;
                detune[i] <= '0;
                wave[i] <= WAVE_SINE;
            end
        end else if (cfg_we) begin
            if (cfg_field == CFG_COARSE) coarse[cfg_osc] <= cfg_data;
            if (cfg_field == CFG_DETUNE) detune[cfg_osc] <= cfg_data;
            if (cfg_field == CFG_WAVE) wave[cfg_osc] <= wave_t'(cfg_data[1:0]);
        end

    // Forwarding only matters when the same slot is read right after its write-back
    always_ff @(posedge sCLK_XVXOSC) begin
        if (we) ram[wr_addr] <= wr_data;
        ram_q <= ram[slot];
        fwd <= we && wr_addr == slot;
        fwd_data <= wr_data;
    end

    assign phase = fwd ? fwd_data : ram_q;
    assign vx1 = s1_slot[S_W-1 -: V_WIDTH];
    assign ox1 = s1_slot[O_WIDTH-1:0];
    assign next = phase + s1_pitch + {{(PHASE_W-8){detune[ox1][7]}}, detune[ox1]};
    assign we = clear || s1_valid;
    assign wr_addr = clear ? slot : s1_slot;
    assign wr_data = clear || (sync_zero[vx1] && ox1 != '0) ? '0 : next;

    assign ox2 = s2_slot[O_WIDTH-1:0];
    assign addr = s2_phase[PHASE_W-1 -: LUT_AW] + (LUT_AW'(coarse[ox2]) << (LUT_AW - 8));

    osc_sine_rom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_rom (
        .sCLK_XVXOSC(sCLK_XVXOSC),
        .addr(addr),
        .q(rom_q)
    );

    assign fold = s3_addr[LUT_AW-1] ? ~s3_addr[LUT_AW-2:0] : s3_addr[LUT_AW-2:0];
    assign saw = {~s3_addr[LUT_AW-1], s3_addr[LUT_AW-2:0], {(OUT_W-LUT_AW){1'b0}}};
    assign sq = s3_addr[LUT_AW-1] ? -AMP : AMP;
    assign tri_v = {~fold[LUT_AW-2], fold[LUT_AW-3:0], {(OUT_W-LUT_AW+1){1'b0}}};
    assign shaped = s3_wave == WAVE_SINE ? rom_q :
                    s3_wave == WAVE_SAW ? saw :
                    s3_wave == WAVE_SQUARE ? sq : tri_v;

    always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N)
        if (!reset_data_N) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_slot <= '0;
            s2_slot <= '0;
            s3_slot <= '0;
            s1_pitch <= '0;
            s2_phase <= '0;
            s3_addr <= '0;
            s3_wave <= WAVE_SINE;
            wave_valid <= 1'b0;
            wave_vx <= '0;
            wave_ox <= '0;
            wave_out <= '0;
        end else begin
            s1_valid <= !clear;
            s1_slot <= slot;
            s1_pitch <= pitch_val;
            s2_valid <= s1_valid;
            s2_slot <= s1_slot;
            s2_phase <= phase;
            s3_valid <= s2_valid;
            s3_slot <= s2_slot;
            s3_addr <= addr;
            s3_wave <= wave[ox2];
            wave_valid <= s3_valid;
            wave_vx <= s3_slot[S_W-1 -: V_WIDTH];
            wave_ox <= s3_slot[O_WIDTH-1:0];
            wave_out <= shaped;
        end
endmodule

// File: tb/tb_osc_wave_gen.sv
// tb_osc_wave_gen: directed stimulus with a slot-level expectation queue and a separate output monitor.
module tb_osc_wave_gen;
    logic clk = 1'b0;
    logic reset_data_N = 1'b0;
    logic slot_start = 1'b0;
    logic [23:0] pitch_val = '0;
    logic [7:0] sync_zero = '0;
    logic cfg_we = 1'b0;
    logic [1:0] cfg_osc = '0;
    logic [1:0] cfg_field = '0;
    logic [7:0] cfg_data = '0;
    logic signed [16:0] wave_out;
    logic wave_valid;
    logic [2:0] wave_vx;
    logic [1:0] wave_ox;

    osc_wave_gen dut (
        .sCLK_XVXOSC(clk),
        .reset_data_N(reset_data_N),
        .slot_start(slot_start),
        .pitch_val(pitch_val),
        .sync_zero(sync_zero),
        .cfg_we(cfg_we),
        .cfg_osc(cfg_osc),
        .cfg_field(cfg_field),
        .cfg_data(cfg_data),
        .wave_out(wave_out),
        .wave_valid(wave_valid),
        .wave_vx(wave_vx),
        .wave_ox(wave_ox)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] vx;
        logic [1:0] ox;
        bit chk;
        logic signed [16:0] val;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int s = 0;
    bit run = 0;
    bit seen = 0;
    bit draining = 0;
    int clr_cnt = 0;
    logic [23:0] pitch_tab [32];
    logic [23:0] ph [32];
    logic [7:0] crs [4];
    logic [7:0] det [4];
    logic [1:0] wv [4];

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One slot: apply config, predict the sample, advance the phase model, then one clock
    task automatic tick();
        int e;
        logic [10:0] a;
        exp_t x;
        e = slot_start ? 0 : s;
        pitch_val = pitch_tab[e];
        if (cfg_we)
            case (cfg_field)
                2'd0: crs[cfg_osc] = cfg_data;
                2'd1: det[cfg_osc] = cfg_data;
                2'd2: wv[cfg_osc] = cfg_data[1:0];
                default: ;
            endcase
        if (run) begin
            a = ph[e][23:13] + {crs[e % 4], 3'b000};
            x.vx = 3'(e / 4);
            x.ox = 2'(e % 4);
            x.chk = 1'b1;
            case (wv[e % 4])
                2'd1: x.val = 17'((int'(a) - 1024) * 64);
                2'd2: x.val = a >= 11'd1024 ? -17'sd65535 : 17'sd65535;
                2'd3: x.val = 17'(((a < 11'd1024 ? int'(a) : 2047 - int'(a)) - 512) * 128);
                default: begin
                    x.val = a == 11'h000 ? 17'sd101 : a == 11'h200 ? 17'sd65535 :
                            a == 11'h400 ? -17'sd101 : -17'sd65535;
                    x.chk = a == 11'h000 || a == 11'h200 || a == 11'h400 || a == 11'h600;
                end
            endcase
            q.push_back(x);
            ph[e] = (sync_zero[e / 4] && e % 4 != 0) ? 24'd0 :
                    ph[e] + pitch_tab[e] + {{16{det[e % 4][7]}}, det[e % 4]};
        end else if (e == 31) begin
            run = 1;
        end
        s = (e + 1) % 32;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        slot_start = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n * 32) tick();
    endtask

    // Write lands while the target oscillator is in stage 0, so no in-flight slot straddles it
    task automatic cfg(input int osc, input int field, input int data);
        while (s % 4 != osc) tick();
        cfg_we = 1'b1;
        cfg_osc = 2'(osc);
        cfg_field = 2'(field);
        cfg_data = 8'(data);
        tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_data_N) begin
            if (!seen) begin
                if (wave_valid) begin
                    seen = 1;
                    check("clear_cycles", clr_cnt, 36);
                end else begin
                    clr_cnt++;
                end
            end
            if (wave_valid) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("vx", int'(wave_vx), int'(e.vx));
                    check("ox", int'(wave_ox), int'(e.ox));
                    if (e.chk) check($sformatf("value_%0d_%0d", e.vx, e.ox), int'(wave_out), int'(e.val));
                end else if (!draining) begin
                    check("unexpected_valid", 1, 0);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            pitch_tab[i] = '0;
            ph[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            crs[i] = '0;
            det[i] = '0;
            wv[i] = '0;
        end
        #2;
        check("reset_valid", int'(wave_valid), 0);
        check("reset_out", int'(wave_out), 0);
        repeat (3) @(posedge clk);
        #1;
        reset_data_N = 1'b1;
        frames(3);
        cfg(0, 2, 1);
        pitch_tab[0] = 24'h010000;
        frames(260);
        pitch_tab[0] = '0;
        cfg(1, 2, 2);
        pitch_tab[1] = 24'h800000;
        frames(4);
        pitch_tab[1] = '0;
        cfg(2, 0, 8'h40);
        frames(2);
        cfg(1, 2, 1);
        cfg(2, 2, 1);
        cfg(3, 2, 3);
        for (int i = 12; i < 16; i++) pitch_tab[i] = 24'h100000;
        frames(3);
        while (s != 0) tick();
        sync_zero = 8'h08;
        frames(1);
        sync_zero = '0;
        frames(2);
        cfg(0, 1, 8'hFF);
        pitch_tab[0] = 24'h010000;
        frames(3);
        while (s != 13) tick();
        slot_start = 1'b1;
        tick();
        frames(2);
        draining = 1;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", q.size(), 0);
        check("first_valid_seen", int'(seen), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
